seq_miter_checker: RTL and testbench
====================================

# seq_miter_checker

Synthesizable, clocked multi-channel miter comparator for the equivalence flow's gold/gate partitions. It generalises the single-bit, purely combinational output compare to `NUM_CH` channels of `WIDTH` bits. It honours a per-bit gold-defined mask, which stands in for the `=== 1'bx` don't-care. It adds a settle window, a bounded check window, sticky failure capture and saturating mismatch counting. It sits between the instantiated gold and gate netlists of a partition and drives pass/fail status to the simulation or emulation harness.

## Interface
- `WIDTH`, 1: bits per channel
- `NUM_CH`, 4: number of compared channels
- `SETTLE`, 2: cycles ignored after arm, min 0
- `CHECK_CYCLES`, 16: valid samples compared before done, min 1
- `CNT_W`, 8: mismatch counter width
- `STOP_ON_FAIL`, 0: 1 ends the check on the first mismatch

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `arm` in 1: start or restart a check
- `sample_valid` in 1: current gold/gate values are a sample
- `gold_out` in NUM_CH*WIDTH: gold outputs; channel c is bits [c*WIDTH +: WIDTH]
- `gate_out` in NUM_CH*WIDTH: gate outputs, same packing
- `gold_def` in NUM_CH*WIDTH: 1 = gold bit defined; 0 = don't-care
- `busy` out 1: state is SETTLE or COMPARE
- `done` out 1: check finished, sticky until arm or rst
- `pass` out 1: valid only when done; 1 if mismatch_cnt == 0
- `mismatch` out 1: sticky, set on the first failing sample
- `first_ch` out $clog2(NUM_CH) (min 1): lowest failing channel of the first failing sample
- `first_idx` out $clog2(CHECK_CYCLES+1): sample index (0-based) of the first failure
- `mismatch_cnt` out CNT_W: failing samples, saturating at all-ones

## Operation
- Channel fail:
  - `|(gold_def[c] & (gold_out[c] ^ gate_out[c]))`.
  - A sample fails if any channel fails.
- State IDLE:
  - All outputs are 0.
  - `arm` moves to SETTLE, or straight to COMPARE if SETTLE == 0.
- State SETTLE:
  - The counter counts SETTLE cycles regardless of `sample_valid`.
  - It then moves to COMPARE.
  - No comparisons are made.
- State COMPARE:
  - Each cycle with `sample_valid`:
    - increment the sample index;
    - on a failing sample, increment `mismatch_cnt` with saturation;
    - on the first failure, set `mismatch` and capture `first_ch` (priority: lowest index) and `first_idx`.
  - The state moves to DONE once the sample index reaches CHECK_CYCLES.
  - With STOP_ON_FAIL = 1, it also moves to DONE on the first failing sample.
- State DONE:
  - `done` = 1; `pass` = !mismatch.
  - All status holds.
  - `arm` clears status and re-enters SETTLE/COMPARE.
- Restart:
  - `arm` in SETTLE or COMPARE clears all status and counters and restarts SETTLE.
- Ignored events:
  - `arm` in the same cycle as `rst` is ignored.
  - `sample_valid` outside COMPARE is ignored.
  - `gold_def` = 0 masks the bit unconditionally, including when gate is mismatched.
- Reset:
  - `rst` returns to IDLE from any state, including mid-check.
  - All outputs go to 0, and `pass` goes to 0.

## Timing
- All outputs are registered.
- A failing sample at edge N is visible on `mismatch`/`mismatch_cnt` after edge N.
- `done` rises the cycle after the sample that completes CHECK_CYCLES, or after the first failure when STOP_ON_FAIL = 1.
- `arm` at edge N gives `busy` = 1 from N+1.
- The first comparable sample is at edge N+1+SETTLE.
- Counter widths are fixed at elaboration.
- The sample index never wraps: it stops at CHECK_CYCLES.

## Structure
- Shared package `miter_pkg`:
  - state enum `miter_state_t` {IDLE, SETTLE, COMPARE, DONE};
  - a `clog2_min1` function for index widths.
- Sub-module `miter_chan_cmp`:
  - combinational, one per channel via generate;
  - inputs gold, gate and def of WIDTH bits; output fail.
- The top level holds the FSM, the counters, and the lowest-index priority encoder over the fail vector.

## Test plan
Unless noted, all scenarios use WIDTH=4, NUM_CH=2, SETTLE=2, CHECK_CYCLES=8, STOP_ON_FAIL=0.
- Identical gold/gate, `gold_def` all 1s, arm, 8 valid samples:
  - `done` = 1 the cycle after the 8th sample;
  - `pass` = 1; `mismatch_cnt` = 0.
- Gate channel 1 = 4'hA vs gold 4'hB on samples 3 and 5:
  - `mismatch` set after sample 3;
  - `first_ch` = 1; `first_idx` = 3; `mismatch_cnt` = 2; `pass` = 0.
- Same mismatch on channel 1 but `gold_def` channel 1 = 4'hE (differing bit masked):
  - `pass` = 1; `mismatch_cnt` = 0.
- STOP_ON_FAIL=1, channels 0 and 1 both fail on sample 2:
  - `done` the next cycle;
  - `first_ch` = 0; `first_idx` = 2; `mismatch_cnt` = 1.
- Mismatches during the SETTLE cycles, then clean samples:
  - `pass` = 1.
- `rst` asserted mid-COMPARE after a failure:
  - next cycle all outputs are 0 and the state is IDLE;
  - a fresh `arm` runs a clean pass.
- Separate bench with CNT_W=2: 5 failing samples give `mismatch_cnt` = 3 (saturated).

Source files
------------

// File: rtl/miter_pkg.sv
// miter_pkg: shared types for the sequential gold/gate miter.
// Provides the checker state enum and an index-width helper.
package miter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } miter_state_t;

  // Width of an index able to hold 0..n-1, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/miter_chan_cmp.sv
// miter_chan_cmp: one channel of the miter, gold vs gate under a define mask.
// Ports: gold, gate, def (WIDTH bits each) in; fail out.
module miter_chan_cmp #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] gold,
  input  logic [WIDTH-1:0] gate,
  input  logic [WIDTH-1:0] def,
  output logic             fail
);

  assign fail = |(def & (gold ^ gate));

endmodule

// File: rtl/seq_miter_checker.sv
// seq_miter_checker: clocked multi-channel miter with settle/check windows.
// Ports: clk, rst, arm, sample_valid, gold/gate/def buses in; status out.
module seq_miter_checker
  import miter_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int NUM_CH       = 4,
  parameter int SETTLE       = 2,
  parameter int CHECK_CYCLES = 16,
  parameter int CNT_W        = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  arm,
  input  logic                                  sample_valid,
  input  logic [NUM_CH*WIDTH-1:0]               gold_out,
  input  logic [NUM_CH*WIDTH-1:0]               gate_out,
  input  logic [NUM_CH*WIDTH-1:0]               gold_def,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pass,
  output logic                                  mismatch,
  output logic [clog2_min1(NUM_CH)-1:0]         first_ch,
  output logic [clog2_min1(CHECK_CYCLES+1)-1:0] first_idx,
  output logic [CNT_W-1:0]                      mismatch_cnt
);

  localparam int CHW = clog2_min1(NUM_CH);
  localparam int IDW = clog2_min1(CHECK_CYCLES + 1);
  localparam int STW = clog2_min1(SETTLE + 1);

  localparam logic [STW-1:0] SETTLE_LAST =
    STW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [IDW-1:0] IDX_LAST = IDW'(CHECK_CYCLES - 1);

  // A zero-length settle window skips straight to comparing.
  localparam miter_state_t ARM_STATE =
    (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;

  logic [NUM_CH-1:0] ch_fail;
  logic [CHW-1:0]    low_ch;
  logic              sample_fail;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    miter_chan_cmp #(
      .WIDTH(WIDTH)
    ) u_cmp (
      .gold(gold_out[c*WIDTH +: WIDTH]),
      .gate(gate_out[c*WIDTH +: WIDTH]),
      .def (gold_def[c*WIDTH +: WIDTH]),
      .fail(ch_fail[c])
    );
  end

  // Scan high to low so the lowest failing channel wins.
  always_comb begin
    low_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_fail[c]) low_ch = CHW'(c);
    end
  end

  assign sample_fail = |ch_fail;

  miter_state_t   state_q, state_d;
  logic [STW-1:0] settle_q, settle_d;
  logic [IDW-1:0] idx_q, idx_d;
  logic           mism_q, mism_d;
  logic [CHW-1:0] fch_q, fch_d;
  logic [IDW-1:0] fidx_q, fidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    mism_d   = mism_q;
    fch_d    = fch_q;
    fidx_d   = fidx_q;
    cnt_d    = cnt_q;
    if (arm) begin
      state_d  = ARM_STATE;
      settle_d = '0;
      idx_d    = '0;
      mism_d   = 1'b0;
      fch_d    = '0;
      fidx_d   = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d = ST_COMPARE;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        ST_COMPARE: begin
          if (sample_valid) begin
            idx_d = idx_q + 1'b1;
            if (sample_fail) begin
              if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
              if (!mism_q) begin
                mism_d = 1'b1;
                fch_d  = low_ch;
                fidx_d = idx_q;
              end
            end
            if (idx_q == IDX_LAST ||
                (STOP_ON_FAIL != 0 && sample_fail)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      idx_q    <= '0;
      mism_q   <= 1'b0;
      fch_q    <= '0;
      fidx_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      mism_q   <= mism_d;
      fch_q    <= fch_d;
      fidx_q   <= fidx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy         = (state_q == ST_SETTLE) ||
                        (state_q == ST_COMPARE);
  assign done         = (state_q == ST_DONE);
  assign pass         = done && !mism_q;
  assign mismatch     = mism_q;
  assign first_ch     = fch_q;
  assign first_idx    = fidx_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_seq_miter_checker.sv
// tb_seq_miter_checker: self-checking bench for seq_miter_checker.
// Three instances: default, STOP_ON_FAIL=1, and CNT_W=2 saturation.
module tb_seq_miter_checker;

  typedef struct {
    logic [7:0] fmask;
    logic       both;
    logic [3:0] def1;
    logic       settle_bad;
    logic       gap;
    logic       pass;
    logic       mism;
    logic [7:0] cnt;
    logic       fch;
    logic [3:0] fidx;
  } vec_t;

  typedef struct {
    logic       pass;
    logic       mism;
    logic [7:0] cnt;
    logic       fch;
    logic [3:0] fidx;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];
  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic arm_a = 1'b0;
  logic arm_s = 1'b0;
  logic arm_c = 1'b0;
  logic [7:0] gold = 8'hB3;
  logic [7:0] gate = 8'hB3;
  logic [7:0] def = 8'hFF;

  logic busy_a, done_a, pass_a, mismatch_a;
  logic [0:0] fch_a;
  logic [3:0] fidx_a;
  logic [7:0] cnt_a;
  logic busy_s, done_s, pass_s, mismatch_s;
  logic [0:0] fch_s;
  logic [3:0] fidx_s;
  logic [7:0] cnt_s;
  logic busy_c, done_c, pass_c, mismatch_c;
  logic [0:0] fch_c;
  logic [3:0] fidx_c;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  seq_miter_checker #(
    .WIDTH(4), .NUM_CH(2), .SETTLE(2),
    .CHECK_CYCLES(8), .CNT_W(8), .STOP_ON_FAIL(0)
  ) dut_a (
    .clk(clk), .rst(rst), .arm(arm_a),
    .sample_valid(valid),
    .gold_out(gold), .gate_out(gate), .gold_def(def),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .mismatch(mismatch_a), .first_ch(fch_a),
    .first_idx(fidx_a), .mismatch_cnt(cnt_a)
  );

  seq_miter_checker #(
    .WIDTH(4), .NUM_CH(2), .SETTLE(2),
    .CHECK_CYCLES(8), .CNT_W(8), .STOP_ON_FAIL(1)
  ) dut_s (
    .clk(clk), .rst(rst), .arm(arm_s),
    .sample_valid(valid),
    .gold_out(gold), .gate_out(gate), .gold_def(def),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .mismatch(mismatch_s), .first_ch(fch_s),
    .first_idx(fidx_s), .mismatch_cnt(cnt_s)
  );

  seq_miter_checker #(
    .WIDTH(4), .NUM_CH(2), .SETTLE(2),
    .CHECK_CYCLES(8), .CNT_W(2), .STOP_ON_FAIL(0)
  ) dut_c (
    .clk(clk), .rst(rst), .arm(arm_c),
    .sample_valid(valid),
    .gold_out(gold), .gate_out(gate), .gold_def(def),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .mismatch(mismatch_c), .first_ch(fch_c),
    .first_idx(fidx_c), .mismatch_cnt(cnt_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // bad: gate ch1 = A vs gold B; both: gate ch0 = 2 vs gold 3.
  task automatic set_data(input logic bad, input logic both,
                          input logic [3:0] def1);
    gold = 8'hB3;
    gate = bad ? {4'hA, (both ? 4'h2 : 4'h3)} : 8'hB3;
    def  = {def1, 4'hF};
  endtask

  function automatic vec_t mk(
    input logic [7:0] fmask, input logic both, input logic [3:0] def1,
    input logic settle_bad, input logic gap, input logic pass,
    input logic mism, input logic [7:0] cnt, input logic fch,
    input logic [3:0] fidx);
    vec_t v;
    v.fmask = fmask; v.both = both; v.def1 = def1;
    v.settle_bad = settle_bad; v.gap = gap; v.pass = pass;
    v.mism = mism; v.cnt = cnt; v.fch = fch; v.fidx = fidx;
    return v;
  endfunction

  task automatic wait_pop_a();
    exp_t e;
    int n = 0;
    while (!done_a && n < 40) begin
      step();
      n++;
    end
    if (!done_a) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got 0 expected 1");
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: got 0 expected 1");
    end else begin
      e = sb.pop_front();
      chk("res_done", done_a, 1);
      chk("res_busy", busy_a, 0);
      chk("res_pass", pass_a, e.pass);
      chk("res_mism", mismatch_a, e.mism);
      chk("res_cnt", cnt_a, e.cnt);
      chk("res_fch", fch_a, e.fch);
      chk("res_fidx", fidx_a, e.fidx);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    e.pass = v.pass; e.mism = v.mism; e.cnt = v.cnt;
    e.fch = v.fch; e.fidx = v.fidx;
    sb.push_back(e);
    arm_a = 1'b1;
    valid = 1'b0;
    set_data(1'b0, 1'b0, v.def1);
    step();
    arm_a = 1'b0;
    chk("arm_busy", busy_a, 1);
    chk("arm_clr_mism", mismatch_a, 0);
    chk("arm_clr_cnt", cnt_a, 0);
    for (int s = 0; s < 2; s++) begin
      valid = v.settle_bad;
      set_data(v.settle_bad, 1'b1, v.def1);
      step();
      chk("settle_cnt", cnt_a, 0);
    end
    for (int i = 0; i < 8; i++) begin
      if (v.gap) begin
        valid = 1'b0;
        set_data(1'b1, 1'b1, v.def1);
        step();
      end
      valid = 1'b1;
      set_data(v.fmask[i], v.both, v.def1);
      step();
      chk("done_edge", done_a, (i == 7));
    end
    valid = 1'b0;
    set_data(1'b0, 1'b0, 4'hF);
    wait_pop_a();
  endtask

  initial begin
    tbl[0] = mk(8'h00, 0, 4'hF, 0, 0, 1, 0, 0, 0, 0);
    tbl[1] = mk(8'h28, 0, 4'hF, 0, 0, 0, 1, 2, 1, 3);
    tbl[2] = mk(8'h28, 0, 4'hE, 0, 0, 1, 0, 0, 0, 0);
    tbl[3] = mk(8'h81, 1, 4'hF, 0, 0, 0, 1, 2, 0, 0);
    tbl[4] = mk(8'h80, 0, 4'hF, 0, 0, 0, 1, 1, 1, 7);
    tbl[5] = mk(8'h00, 0, 4'hF, 1, 0, 1, 0, 0, 0, 0);
    tbl[6] = mk(8'h24, 0, 4'hF, 0, 1, 0, 1, 2, 1, 2);
    tbl[7] = mk(8'h81, 1, 4'hE, 0, 0, 0, 1, 2, 0, 0);

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_mism", mismatch_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_done_s", done_s, 0);
    chk("rst_cnt_c", cnt_c, 0);

    for (int k = 0; k < 8; k++) run_vec(tbl[k]);

    // STOP_ON_FAIL: both channels fail on sample 2.
    arm_s = 1'b1;
    valid = 1'b0;
    set_data(1'b0, 1'b0, 4'hF);
    step();
    arm_s = 1'b0;
    chk("stop_busy", busy_s, 1);
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1;
      set_data(1'b0, 1'b0, 4'hF);
      step();
      chk("stop_early_done", done_s, 0);
    end
    set_data(1'b1, 1'b1, 4'hF);
    step();
    chk("stop_done", done_s, 1);
    chk("stop_busy_lo", busy_s, 0);
    chk("stop_fch", fch_s, 0);
    chk("stop_fidx", fidx_s, 2);
    chk("stop_cnt", cnt_s, 1);
    chk("stop_pass", pass_s, 0);
    step();
    step();
    chk("stop_hold_cnt", cnt_s, 1);
    valid = 1'b0;
    set_data(1'b0, 1'b0, 4'hF);

    // Saturation: five failing samples on a 2-bit counter.
    arm_c = 1'b1;
    step();
    arm_c = 1'b0;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      set_data((i < 5), 1'b0, 4'hF);
      step();
      if (i == 2) chk("sat_cnt3", cnt_c, 3);
      if (i == 4) chk("sat_hold", cnt_c, 3);
    end
    valid = 1'b0;
    set_data(1'b0, 1'b0, 4'hF);
    chk("sat_done", done_c, 1);
    chk("sat_mism", mismatch_c, 1);
    chk("sat_pass", pass_c, 0);
    chk("sat_fidx", fidx_c, 0);

    // rst mid-COMPARE after a failure; arm alongside rst is ignored.
    arm_a = 1'b1;
    step();
    arm_a = 1'b0;
    step();
    step();
    valid = 1'b1;
    set_data(1'b1, 1'b0, 4'hF);
    step();
    chk("mid_mism", mismatch_a, 1);
    chk("mid_cnt", cnt_a, 1);
    rst = 1'b1;
    arm_a = 1'b1;
    step();
    rst = 1'b0;
    arm_a = 1'b0;
    chk("mrst_busy", busy_a, 0);
    chk("mrst_done", done_a, 0);
    chk("mrst_pass", pass_a, 0);
    chk("mrst_mism", mismatch_a, 0);
    chk("mrst_fch", fch_a, 0);
    chk("mrst_fidx", fidx_a, 0);
    chk("mrst_cnt", cnt_a, 0);
    step();
    chk("mrst_idle", busy_a, 0);
    valid = 1'b0;
    set_data(1'b0, 1'b0, 4'hF);
    run_vec(tbl[0]);

    // arm mid-COMPARE restarts with cleared status.
    arm_a = 1'b1;
    step();
    arm_a = 1'b0;
    step();
    step();
    valid = 1'b1;
    set_data(1'b1, 1'b1, 4'hF);
    step();
    chk("rs_mism", mismatch_a, 1);
    arm_a = 1'b1;
    step();
    arm_a = 1'b0;
    chk("rs_busy", busy_a, 1);
    chk("rs_mism_clr", mismatch_a, 0);
    chk("rs_cnt_clr", cnt_a, 0);
    chk("rs_fch_clr", fch_a, 0);
    begin
      exp_t e;
      e.pass = 1'b1; e.mism = 1'b0; e.cnt = 8'd0;
      e.fch = 1'b0; e.fidx = 4'd0;
      sb.push_back(e);
    end
    set_data(1'b0, 1'b0, 4'hF);
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      step();
      chk("rs_done_edge", done_a, (i == 7));
    end
    valid = 1'b0;
    wait_pop_a();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
